// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, wait-counted memory read, IR field decode.
// Optional misaligned-PC fault detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned MEM_LATENCY = 3,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_load_value,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] pc,
    output logic [5:0]  OPCODE,
    output logic [4:0]  RS,
    output logic [4:0]  RT,
    output logic [15:0] OFFSET,
    output logic        fetch_done,
    output logic        busy,
    output logic        align_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        mem_rd_q, mem_rd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    // Next-state, PC/IR update and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_load_value;
                end else if (fetch_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_q[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'd0;
                    end
`else
                    state_d = WAIT;
                    cnt_d   = 3'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    ir_d    = mem_data_in;
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = 3'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (pc_load) begin
                    pc_d    = pc_load_value;
                    state_d = IDLE;
                end else begin
                    state_d = FAULT;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they register in step with it
        mem_rd_d = (state_d == WAIT);
        busy_d   = (state_d == WAIT) || (state_d == DONE);
        done_d   = (state_d == DONE);
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d  = (state_d == FAULT);
`else
        fault_d  = 1'b0;
`endif
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mem_rd_q <= mem_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_addr    = {pc_q[31:2], 2'b00};
    assign mem_rd      = mem_rd_q;
    assign pc          = pc_q;
    assign OPCODE      = ir_q[31:26];
    assign RS          = ir_q[25:21];
    assign RT          = ir_q[20:16];
    assign OFFSET      = ir_q[15:0];
    assign fetch_done  = done_q;
    assign busy        = busy_q;
    assign align_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases plus randomized
// load/fetch/idle traffic checked against a transaction-level PC/IR model.
module tb_fetch_unit;

    localparam int          L   = 3;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, fetch_req, pc_load;
    logic [31:0] pc_load_value, mem_data_in;
    logic [31:0] mem_addr, pc;
    logic        mem_rd, fetch_done, busy, align_fault;
    logic [5:0]  OPCODE;
    logic [4:0]  RS, RT;
    logic [15:0] OFFSET;

    int total = 0;
    int bad   = 0;
    logic [31:0] mpc;
    logic [31:0] mir;

    fetch_unit #(.MEM_LATENCY(L), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .mem_data_in(mem_data_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .pc(pc), .OPCODE(OPCODE),
        .RS(RS), .RT(RT), .OFFSET(OFFSET), .fetch_done(fetch_done),
        .busy(busy), .align_fault(align_fault)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0;
        pc_load_value = 32'd0; mem_data_in = 32'd0;
        tick(); tick();
        reset = 1'b0;
        mpc = RPC; mir = 32'd0;
        total++;
        if (pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, RPC); end
        total++;
        if ({OPCODE, RS, RT, OFFSET} !== 32'd0) begin
            bad++; $display("FAIL reset_ir got=%h want=0", {OPCODE, RS, RT, OFFSET});
        end
        total++;
        if ({mem_rd, busy, fetch_done, align_fault} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {mem_rd, busy, fetch_done, align_fault});
        end
    endtask

    task automatic load_pc(input logic [31:0] v, input bit with_fetch);
        pc_load = 1'b1; pc_load_value = v; fetch_req = with_fetch;
        tick();
        pc_load = 1'b0; fetch_req = 1'b0;
        mpc = v;
        total++;
        if (pc !== mpc) begin bad++; $display("FAIL load_pc got=%h want=%h", pc, mpc); end
        total++;
        if ({mem_rd, busy, fetch_done, align_fault} !== 4'b0000) begin
            bad++; $display("FAIL load_flags got=%b want=0000", {mem_rd, busy, fetch_done, align_fault});
        end
    endtask

    // One fetch from IDLE; optional noise on the control inputs while busy
    task automatic do_fetch(input logic [31:0] word, input bit noise);
        logic [31:0] ea;
        ea = mpc & 32'hFFFF_FFFC;
        mem_data_in = word; fetch_req = 1'b1; pc_load = 1'b0;
        tick();
        fetch_req = 1'b0;
        for (int k = 0; k < L; k++) begin
            total++;
            if ({mem_rd, busy, fetch_done, align_fault} !== 4'b1100 || mem_addr !== ea) begin
                bad++;
                $display("FAIL fetch_wait k=%0d flags=%b addr=%h want flags=1100 addr=%h",
                         k, {mem_rd, busy, fetch_done, align_fault}, mem_addr, ea);
            end
            total++;
            if (pc !== mpc || {OPCODE, RS, RT, OFFSET} !== mir) begin
                bad++; $display("FAIL fetch_hold pc=%h ir=%h want pc=%h ir=%h",
                                pc, {OPCODE, RS, RT, OFFSET}, mpc, mir);
            end
            if (noise) begin
                fetch_req = 1'($urandom_range(0, 1));
                pc_load = 1'($urandom_range(0, 1));
                pc_load_value = $urandom;
            end
            tick();
        end
        mpc = mpc + 32'd4;
        mir = word;
        total++;
        if ({mem_rd, busy, fetch_done, align_fault} !== 4'b0110) begin
            bad++; $display("FAIL fetch_done_flags got=%b want=0110", {mem_rd, busy, fetch_done, align_fault});
        end
        total++;
        if (pc !== mpc || {OPCODE, RS, RT, OFFSET} !== mir) begin
            bad++; $display("FAIL fetch_result pc=%h ir=%h want pc=%h ir=%h",
                            pc, {OPCODE, RS, RT, OFFSET}, mpc, mir);
        end
        if (noise) begin
            fetch_req = 1'($urandom_range(0, 1));
            pc_load = 1'($urandom_range(0, 1));
            pc_load_value = $urandom;
            mem_data_in = $urandom;
        end
        tick();
        fetch_req = 1'b0; pc_load = 1'b0;
        total++;
        if ({mem_rd, busy, fetch_done, align_fault} !== 4'b0000 || pc !== mpc
            || {OPCODE, RS, RT, OFFSET} !== mir) begin
            bad++;
            $display("FAIL fetch_idle flags=%b pc=%h ir=%h want flags=0000 pc=%h ir=%h",
                     {mem_rd, busy, fetch_done, align_fault}, pc, {OPCODE, RS, RT, OFFSET}, mpc, mir);
        end
    endtask

    task automatic test_directed();
        test_reset();
        do_fetch(32'h2008_0005, 1'b0);
        total++;
        if (OPCODE !== 6'b001000 || RS !== 5'd0 || RT !== 5'd8 || OFFSET !== 16'd5 || pc !== 32'd4) begin
            bad++; $display("FAIL directed_decode op=%b rs=%0d rt=%0d off=%h pc=%h want 001000/0/8/0005/4",
                            OPCODE, RS, RT, OFFSET, pc);
        end
    endtask

    task automatic test_wrap();
        load_pc(32'hFFFF_FFFC, 1'b0);
        do_fetch($urandom, 1'b0);
        total++;
        if (pc !== 32'd0) begin bad++; $display("FAIL wrap_pc got=%h want=0", pc); end
    endtask

    task automatic test_load_priority();
        logic [31:0] v;
        v = $urandom & 32'hFFFF_FFFC;
        load_pc(v, 1'b1);
        tick();
        total++;
        if ({mem_rd, busy} !== 2'b00 || pc !== v) begin
            bad++; $display("FAIL load_priority rd/busy=%b pc=%h want 00 pc=%h", {mem_rd, busy}, pc, v);
        end
    endtask

    task automatic test_reset_mid_wait();
        load_pc(32'h0000_0040, 1'b0);
        mem_data_in = $urandom; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mpc = RPC; mir = 32'd0;
        total++;
        if (pc !== RPC || {OPCODE, RS, RT, OFFSET} !== 32'd0
            || {mem_rd, busy, fetch_done, align_fault} !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_wait pc=%h ir=%h flags=%b want pc=%h ir=0 flags=0000",
                            pc, {OPCODE, RS, RT, OFFSET}, {mem_rd, busy, fetch_done, align_fault}, RPC);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (fetch_done !== 1'b0 || pc !== RPC) begin
                bad++; $display("FAIL reset_no_done c=%0d done=%b pc=%h want 0 pc=%h", c, fetch_done, pc, RPC);
            end
        end
    endtask

    // fetch_req held high: IDLE, L wait cycles, DONE repeat every L+2 cycles
    task automatic test_back_to_back();
        int dones[$];
        logic [31:0] addrs[$];
        logic prev_rd;
        logic [31:0] word;
        test_reset();
        word = $urandom;
        mem_data_in = word; fetch_req = 1'b1; prev_rd = 1'b0;
        tick();
        for (int c = 0; c < 3 * (L + 2); c++) begin
            if (mem_rd && !prev_rd) addrs.push_back(mem_addr);
            prev_rd = mem_rd;
            if (fetch_done) dones.push_back(c);
            if (c == 3 * (L + 2) - 1) fetch_req = 1'b0;
            tick();
        end
        mpc = RPC + 32'd12; mir = word;
        total++;
        if (dones.size() != 3 || addrs.size() != 3) begin
            bad++; $display("FAIL b2b_counts dones=%0d reads=%0d want 3/3", dones.size(), addrs.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= dones.size() || dones[i] != L + i * (L + 2)) begin
                bad++; $display("FAIL b2b_done_cycle i=%0d got=%0d want=%0d", i,
                                (i < dones.size()) ? dones[i] : -1, L + i * (L + 2));
            end
            total++;
            if (i >= addrs.size() || addrs[i] !== RPC + 32'(4 * i)) begin
                bad++; $display("FAIL b2b_addr i=%0d got=%h want=%h", i,
                                (i < addrs.size()) ? addrs[i] : 32'hDEAD_BEEF, RPC + 32'(4 * i));
            end
        end
        total++;
        if (pc !== mpc || busy !== 1'b0 || {OPCODE, RS, RT, OFFSET} !== mir) begin
            bad++; $display("FAIL b2b_end pc=%h busy=%b want pc=%h busy=0", pc, busy, mpc);
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        test_reset();
        load_pc(32'h0000_0002, 1'b0);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({mem_rd, busy, fetch_done, align_fault} !== 4'b0001) begin
                bad++; $display("FAIL align_fault c=%0d flags=%b want=0001", c, {mem_rd, busy, fetch_done, align_fault});
            end
            fetch_req = 1'($urandom_range(0, 1));
            tick();
        end
        fetch_req = 1'b0;
        load_pc(32'h0000_0008, 1'b0);
        do_fetch($urandom, 1'b0);
    endtask
`else
    task automatic test_misaligned();
        logic [31:0] v;
        v = $urandom;
        v[1:0] = 2'b10;
        load_pc(v, 1'b0);
        do_fetch($urandom, 1'b0);
        total++;
        if (pc[1:0] !== 2'b10 || align_fault !== 1'b0) begin
            bad++; $display("FAIL misaligned_ignored pc=%h fault=%b want low bits 10 fault 0", pc, align_fault);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] v;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
                    v[1:0] = 2'b00;
`endif
                    load_pc(v, 1'($urandom_range(0, 1)));
                end
                1, 2: do_fetch($urandom, 1'b1);
                3: begin
                    mem_data_in = $urandom;
                    tick();
                    total++;
                    if (pc !== mpc || {OPCODE, RS, RT, OFFSET} !== mir
                        || {mem_rd, busy, fetch_done, align_fault} !== 4'b0000) begin
                        bad++; $display("FAIL random_idle pc=%h ir=%h want pc=%h ir=%h",
                                        pc, {OPCODE, RS, RT, OFFSET}, mpc, mir);
                    end
                end
                default: tick();
            endcase
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0;
        pc_load_value = 32'd0; mem_data_in = 32'd0;
        test_reset();
        test_directed();
        test_wrap();
        test_load_priority();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`else
        test_misaligned();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
